// File: rtl/jtkicker_gfx_pkg.sv
// jtkicker_gfx_pkg: shared FSM encoding and port indices for the graphics ROM arbiter
package jtkicker_gfx_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, FETCH = 2'd2} state_t;
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;
endpackage

// File: rtl/jtkicker_gfx_arb_if.sv
// jtkicker_gfx_arb_if: requester ports A/B and the SDRAM slot of the graphics ROM arbiter
interface jtkicker_gfx_arb_if #(parameter int AW = 13, parameter int DW = 32);
  logic          LHBL;
  logic [AW-1:0] a_addr, b_addr, rom_addr;
  logic          a_cs, a_ok, b_cs, b_ok, rom_cs, rom_ok;
  logic [DW-1:0] a_data, b_data, rom_data;
  modport slave (
    input  LHBL, a_addr, a_cs, b_addr, b_cs, rom_ok, rom_data,
    output a_ok, a_data, b_ok, b_data, rom_addr, rom_cs
  );
  modport master (
    output LHBL, a_addr, a_cs, b_addr, b_cs, rom_ok, rom_data,
    input  a_ok, a_data, b_ok, b_data, rom_addr, rom_cs
  );
endinterface

// File: rtl/jtkicker_gfx_cache.sv
// jtkicker_gfx_cache: one-entry tag/valid/data result cache for a single requester
module jtkicker_gfx_cache #(parameter int AW = 13, parameter int DW = 32) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr,
  input  logic          cs,
  input  logic          fill,
  input  logic [AW-1:0] fill_addr,
  input  logic [DW-1:0] fill_data,
  output logic          ok,
  output logic          need,
  output logic [DW-1:0] data
);
  logic [AW-1:0] tag;
  logic          vld;
  logic          hit;
  always_ff @(posedge clk)
    if (!rst_n) begin
      tag  <= '0;
      vld  <= 1'b0;
      data <= '0;
    end else if (fill) begin
      tag  <= fill_addr;
      vld  <= 1'b1;
      data <= fill_data;
    end
  // ok follows the live address, so it drops in the same cycle the address moves
  assign hit  = vld && addr == tag;
  assign ok   = cs && hit;
  assign need = cs && !hit;
endmodule

// File: rtl/jtkicker_gfx_arb.sv
// jtkicker_gfx_arb: shares one SDRAM graphics ROM slot between object (A) and tile (B) fetchers
module jtkicker_gfx_arb
  import jtkicker_gfx_pkg::*;
#(
  parameter int AW   = 13,
  parameter int DW   = 32,
  parameter int FAIR = 1
) (
  input logic               clk,
  input logic               rst_n,
  jtkicker_gfx_arb_if.slave bus
);
  state_t        state, state_nxt;
  logic          gnt, gnt_nxt, ptr, ptr_nxt, cs_nxt;
  logic [AW-1:0] addr_nxt;
  logic          need_a, need_b, pick_b, fill;
  assign fill = state == FETCH && bus.rom_ok;
  jtkicker_gfx_cache #(.AW(AW), .DW(DW)) ca (
    .clk(clk), .rst_n(rst_n), .addr(bus.a_addr), .cs(bus.a_cs),
    .fill(fill && gnt == PORT_A), .fill_addr(bus.rom_addr), .fill_data(bus.rom_data),
    .ok(bus.a_ok), .need(need_a), .data(bus.a_data)
  );
  jtkicker_gfx_cache #(.AW(AW), .DW(DW)) cb (
    .clk(clk), .rst_n(rst_n), .addr(bus.b_addr), .cs(bus.b_cs),
    .fill(fill && gnt == PORT_B), .fill_addr(bus.rom_addr), .fill_data(bus.rom_data),
    .ok(bus.b_ok), .need(need_b), .data(bus.b_data)
  );
  // outside horizontal blank a tie goes to whichever port was not served last
  assign pick_b = need_b && (!need_a || (FAIR != 0 && bus.LHBL && ptr == PORT_B));
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    ptr_nxt   = ptr;
    cs_nxt    = bus.rom_cs;
    addr_nxt  = bus.rom_addr;
    case (state)
      IDLE:
        if (need_a || need_b) begin
          state_nxt = SETTLE;
          gnt_nxt   = pick_b;
          cs_nxt    = 1'b1;
          addr_nxt  = pick_b ? bus.b_addr : bus.a_addr;
        end
      SETTLE: state_nxt = FETCH;
      FETCH:
        if (bus.rom_ok) begin
          state_nxt = IDLE;
          cs_nxt    = 1'b0;
          ptr_nxt   = ~gnt;
        end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state        <= IDLE;
      gnt          <= PORT_A;
      ptr          <= PORT_A;
      bus.rom_cs   <= 1'b0;
      bus.rom_addr <= '0;
    end else begin
      state        <= state_nxt;
      gnt          <= gnt_nxt;
      ptr          <= ptr_nxt;
      bus.rom_cs   <= cs_nxt;
      bus.rom_addr <= addr_nxt;
    end
endmodule

// File: tb/tb_jtkicker_gfx_arb.sv
// tb_jtkicker_gfx_arb: directed tables, corner sequences and a random run against an event-level model
module tb_jtkicker_gfx_arb;
  localparam int AW = 13;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic          lhbl, a_cs, b_cs;
  logic [AW-1:0] a_addr, b_addr;
  jtkicker_gfx_arb_if #(.AW(AW), .DW(DW)) bf ();
  jtkicker_gfx_arb_if #(.AW(AW), .DW(DW)) b0 ();
  jtkicker_gfx_arb #(.AW(AW), .DW(DW), .FAIR(1)) dut  (.clk(clk), .rst_n(rst_n), .bus(bf.slave));
  jtkicker_gfx_arb #(.AW(AW), .DW(DW), .FAIR(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  assign bf.LHBL = lhbl;
  assign bf.a_cs = a_cs;
  assign bf.a_addr = a_addr;
  assign bf.b_cs = b_cs;
  assign bf.b_addr = b_addr;
  assign b0.LHBL = lhbl;
  assign b0.a_cs = a_cs;
  assign b0.a_addr = a_addr;
  assign b0.b_cs = b_cs;
  assign b0.b_addr = b_addr;
  function automatic logic [31:0] f(input logic [AW-1:0] a);
    return (32'(a) * 32'h9E3779B1) ^ 32'h00C3A500;
  endfunction
  // SDRAM slot: data lags the address by one cycle, ok after lat cycles of rom_cs
  int          lat = 4;
  logic        always_ok = 1'b0, force_ok = 1'b0, use_fixed = 1'b0;
  logic [31:0] fixed = 32'h0;
  int          cnt_f = 0, cnt_0 = 0;
  logic [31:0] dq_f = 32'h0, dq_0 = 32'h0;
  always @(posedge clk) begin
    cnt_f <= bf.rom_cs ? cnt_f + 1 : 0;
    cnt_0 <= b0.rom_cs ? cnt_0 + 1 : 0;
    dq_f  <= use_fixed ? fixed : f(bf.rom_addr);
    dq_0  <= use_fixed ? fixed : f(b0.rom_addr);
  end
  assign bf.rom_ok   = always_ok || force_ok || (bf.rom_cs && cnt_f >= lat);
  assign b0.rom_ok   = always_ok || force_ok || (b0.rom_cs && cnt_0 >= lat);
  assign bf.rom_data = dq_f;
  assign b0.rom_data = dq_0;
  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask
  // event-level reference for the FAIR=1 instance: a grant completes a fixed time later
  logic          m_busy, m_g, m_ptr, m_rcs;
  int            m_fill_at, m_n;
  logic          m_vld[2];
  logic [AW-1:0] m_tag[2];
  logic [AW-1:0] m_raddr;
  logic [31:0]   m_dat[2];
  task automatic m_reset;
    m_busy = 0; m_g = 0; m_ptr = 0; m_rcs = 0; m_raddr = '0; m_n = 0; m_fill_at = 0;
    for (int i = 0; i < 2; i++) begin
      m_vld[i] = 0; m_tag[i] = '0; m_dat[i] = '0;
    end
  endtask
  task automatic m_step;
    logic na, nb, pb;
    m_n++;
    na = a_cs && !(m_vld[0] && m_tag[0] == a_addr);
    nb = b_cs && !(m_vld[1] && m_tag[1] == b_addr);
    if (m_busy) begin
      if (m_n == m_fill_at) begin
        m_vld[m_g] = 1'b1;
        m_tag[m_g] = m_raddr;
        m_dat[m_g] = f(m_raddr);
        m_rcs = 0;
        m_busy = 0;
        m_ptr = !m_g;
      end
    end else if (na || nb) begin
      pb = nb && (!na || (lhbl && m_ptr));
      m_g = pb;
      m_raddr = pb ? b_addr : a_addr;
      m_rcs = 1;
      m_busy = 1;
      m_fill_at = m_n + (lat > 1 ? lat : 1) + 1;
    end
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    @(posedge clk);
    m_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  logic got[$];
  logic pc;
  task automatic collect(input int want);
    for (int c = 0; c < 200 && got.size() < want; c++) begin
      tick();
      if (bf.rom_cs && !pc) got.push_back(bf.rom_addr >= 13'h200);
      pc = bf.rom_cs;
      if (bf.a_ok) a_addr++;
      if (bf.b_ok) b_addr++;
    end
  endtask
  typedef struct {
    logic acs; logic [AW-1:0] aa; logic bcs; logic [AW-1:0] ba;
    logic rcs; logic [AW-1:0] ra; logic aok; logic bok;
  } vec_t;
  vec_t tbl[14];
  initial begin
    tbl[0]  = '{1'b1, 13'h123, 1'b0, 13'h000, 1'b0, 13'h000, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 13'h123, 1'b0, 13'h000, 1'b1, 13'h123, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 13'h123, 1'b0, 13'h000, 1'b1, 13'h123, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 13'h123, 1'b0, 13'h000, 1'b0, 13'h123, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 13'h123, 1'b0, 13'h000, 1'b0, 13'h123, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 13'h123, 1'b1, 13'h456, 1'b0, 13'h123, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 13'h123, 1'b1, 13'h456, 1'b1, 13'h456, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 13'h123, 1'b1, 13'h456, 1'b1, 13'h456, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 13'h123, 1'b1, 13'h456, 1'b0, 13'h456, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 13'h124, 1'b1, 13'h456, 1'b0, 13'h456, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 13'h124, 1'b1, 13'h456, 1'b1, 13'h124, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 13'h124, 1'b1, 13'h456, 1'b1, 13'h124, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 13'h124, 1'b1, 13'h456, 1'b0, 13'h124, 1'b1, 1'b1};
    tbl[13] = '{1'b0, 13'h124, 1'b0, 13'h456, 1'b0, 13'h124, 1'b0, 1'b0};
    lhbl = 1; a_cs = 0; b_cs = 0; a_addr = '0; b_addr = '0;
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_rom_cs", bf.rom_cs, 0);
    chk("rst_rom_addr", bf.rom_addr, 0);
    chk("rst_a_data", bf.a_data, 0);
    chk("rst_b_data", bf.b_data, 0);
    a_cs = 1; b_cs = 1;
    #1;
    chk("rst_a_ok", bf.a_ok, 0);
    chk("rst_b_ok", bf.b_ok, 0);
    a_cs = 0; b_cs = 0;
    rst_n = 1;
    // reset in the middle of a fetch
    lat = 8; a_cs = 1; a_addr = 13'h077;
    repeat (3) tick();
    chk("t1_in_fetch", bf.rom_cs, 1);
    rst_n = 0;
    tick();
    chk("t1_rom_cs", bf.rom_cs, 0);
    chk("t1_rom_addr", bf.rom_addr, 0);
    chk("t1_a_ok", bf.a_ok, 0);
    chk("t1_b_ok", bf.b_ok, 0);
    a_cs = 0; rst_n = 1; force_ok = 1;
    repeat (3) tick();
    chk("t1_no_refetch", bf.rom_cs, 0);
    force_ok = 0; a_cs = 1;
    #1;
    chk("t1_no_fill", bf.a_ok, 0);
    a_cs = 0;
    // single miss with a 4-cycle SDRAM, then a hit
    do_reset();
    lat = 4; use_fixed = 1; fixed = 32'hDEADBEEF; a_cs = 1; a_addr = 13'h0123;
    tick();
    chk("t2_rom_cs", bf.rom_cs, 1);
    chk("t2_rom_addr", bf.rom_addr, 13'h0123);
    begin
      int k = 1;
      while (!bf.a_ok && k < 20) begin tick(); k++; end
      chk("t2_latency", k, 6);
    end
    chk("t2_a_data", bf.a_data, 32'hDEADBEEF);
    a_cs = 0;
    tick();
    a_cs = 1;
    #1;
    chk("t2_hit_same_cycle", bf.a_ok, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_hit_no_rom", bf.rom_cs, 0);
    end
    use_fixed = 0; a_cs = 0;
    // rom_ok stuck high: sampling must wait for FETCH
    do_reset();
    always_ok = 1;
    for (int i = 0; i < 14; i++) begin
      a_cs = tbl[i].acs; a_addr = tbl[i].aa; b_cs = tbl[i].bcs; b_addr = tbl[i].ba;
      #1;
      chk($sformatf("tbl%0d_rom_cs", i), bf.rom_cs, tbl[i].rcs);
      chk($sformatf("tbl%0d_rom_addr", i), bf.rom_addr, tbl[i].ra);
      chk($sformatf("tbl%0d_a_ok", i), bf.a_ok, tbl[i].aok);
      chk($sformatf("tbl%0d_b_ok", i), bf.b_ok, tbl[i].bok);
      if (tbl[i].aok) chk($sformatf("tbl%0d_a_data", i), bf.a_data, f(tbl[i].aa));
      if (tbl[i].bok) chk($sformatf("tbl%0d_b_data", i), bf.b_data, f(tbl[i].ba));
      tick();
    end
    always_ok = 0; a_cs = 0; b_cs = 0;
    // continuous contention, inside and outside blank
    do_reset();
    lat = 2; lhbl = 1; a_cs = 1; a_addr = 13'h100; b_cs = 1; b_addr = 13'h200;
    got.delete(); pc = 0;
    collect(4);
    chk("t4_rr_count", got.size(), 4);
    for (int i = 0; i < got.size(); i++) chk($sformatf("t4_rr_grant%0d", i), got[i], i % 2);
    do_reset();
    lhbl = 0; a_addr = 13'h100; b_addr = 13'h200;
    got.delete(); pc = 0;
    collect(3);
    a_cs = 0;
    collect(4);
    chk("t4_blank_count", got.size(), 4);
    for (int i = 0; i < got.size(); i++) chk($sformatf("t4_blank_grant%0d", i), got[i], i == 3);
    a_cs = 0; b_cs = 0; lhbl = 1;
    // address change while granted
    do_reset();
    lat = 6; a_cs = 1; a_addr = 13'h0010;
    tick();
    chk("t5_rom_addr", bf.rom_addr, 13'h0010);
    repeat (2) tick();
    a_addr = 13'h0020;
    begin
      int k = 0;
      while (bf.rom_cs && k < 20) begin
        chk("t5_frozen", bf.rom_addr, 13'h0010);
        chk("t5_ok_low", bf.a_ok, 0);
        tick(); k++;
      end
    end
    chk("t5_fill_done", bf.rom_cs, 0);
    chk("t5_ok_after_fill", bf.a_ok, 0);
    tick();
    chk("t5_refetch_cs", bf.rom_cs, 1);
    chk("t5_refetch_addr", bf.rom_addr, 13'h0020);
    begin
      int k = 0;
      while (!bf.a_ok && k < 20) begin tick(); k++; end
    end
    chk("t5_ok", bf.a_ok, 1);
    chk("t5_data", bf.a_data, f(13'h0020));
    a_cs = 0;
    // A served last, then both miss: FAIR=0 favours A, FAIR=1 rotates to B
    do_reset();
    lat = 2; lhbl = 1; a_cs = 1; a_addr = 13'h300;
    begin
      int k = 0;
      while (!bf.a_ok && k < 20) begin tick(); k++; end
    end
    chk("t6_a_first", bf.a_ok, 1);
    chk("t6_fair0_a_first", b0.a_ok, 1);
    a_addr = 13'h301; b_cs = 1; b_addr = 13'h400;
    tick();
    chk("t6_fair0_cs", b0.rom_cs, 1);
    chk("t6_fair0_grant", b0.rom_addr, 13'h301);
    chk("t6_fair1_grant", bf.rom_addr, 13'h400);
    a_cs = 0; b_cs = 0;
    // random traffic against the reference
    for (int s = 0; s < 4; s++) begin
      lat = $urandom_range(0, 3);
      do_reset();
      for (int c = 0; c < 400; c++) begin
        a_cs = $urandom_range(0, 3) != 0;
        b_cs = $urandom_range(0, 3) != 0;
        lhbl = $urandom_range(0, 4) != 0;
        if ($urandom_range(0, 3) == 0) a_addr = 13'(13'h40 + $urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0)
          b_addr = $urandom_range(0, 5) == 0 ? 13'(13'h40 + $urandom_range(0, 3)) : 13'(13'h80 + $urandom_range(0, 3));
        #1;
        chk("r_rom_cs", bf.rom_cs, m_rcs);
        chk("r_rom_addr", bf.rom_addr, m_raddr);
        chk("r_a_ok", bf.a_ok, a_cs && m_vld[0] && m_tag[0] == a_addr);
        chk("r_b_ok", bf.b_ok, b_cs && m_vld[1] && m_tag[1] == b_addr);
        chk("r_a_data", bf.a_data, m_dat[0]);
        chk("r_b_data", bf.b_data, m_dat[1]);
        @(posedge clk);
        m_step();
        @(negedge clk);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
